// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_responder data-memory model.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int LATENCY_MAX = 15;
    localparam int WORD_BYTES  = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, contents not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    input  logic          re,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with valid/ready request and response ports.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int OFS = $clog2(WORD_BYTES);
    localparam int CW  = $clog2(LATENCY_MAX + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic          misaligned;
    logic          accept;
    logic          access;
    logic [31:0]   arr_rdata;

    assign accept = (state_q == IDLE) && req_valid;
    assign access = (state_q == WAIT) && (cnt_q == '0);

`ifdef DMEM_ALIGN_CHECK_EN
    logic mis_q;
    logic unused_addr;
    assign unused_addr = ^req_addr[31:AW+OFS];
    assign misaligned  = mis_q;
`else
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:AW+OFS], req_addr[OFS-1:0]};
    assign misaligned  = 1'b0;
`endif

    // Request payload is only sampled at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[AW+OFS-1:OFS];
            wdata_q <= req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
            mis_q   <= |req_addr[OFS-1:0];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RESP;
                    err_d   = misaligned;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A flagged access touches neither the write port nor the read register.
    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (access && we_q && !misaligned),
        .idx   (idx_q),
        .wdata (wdata_q),
        .re    (access && !we_q && !misaligned),
        .rdata (arr_rdata)
    );

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    // Read data is visible only while a load response is presented.
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? arr_rdata : 32'h0;

endmodule
